// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Purpose  : RV32I instruction-fetch stage. Owns the PC, issues one request
//            at a time to instruction memory over ready/valid, loads fetched
//            words into the IF/ID register, handles stall, flush, and discards
//            an in-flight response when the PC is redirected.
// Options  : FETCH_PERF_EN adds saturating fetchCount/dropCount outputs.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pcNext,
  input  logic [1:0]  pcSrc,
  input  logic        stallD,
  input  logic        flushD,
  output logic        imemReq,
  output logic [31:0] imemAddr,
  input  logic        imemReady,
  input  logic        imemRvalid,
  input  logic [31:0] imemRdata,
  output logic [31:0] pcF,
  output logic [31:0] pcPlus4F,
  output logic [31:0] instrD,
  output logic [31:0] pcD,
  output logic [31:0] pcPlus4D,
`ifdef FETCH_PERF_EN
  output logic [31:0] fetchCount,
  output logic [31:0] dropCount,
`endif
  output logic        validD
);

  // S_REQ : request presented at pcF
  // S_WAIT: request accepted, waiting for the word
  // S_HOLD: word arrived while decode was stalled; parked in hold register
  // S_DROP: response still in flight for a PC that has been redirected away
  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2,
    S_DROP = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] hold_q, hold_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pcD_q, pcD_d;
  logic [31:0] pcp4D_q, pcp4D_d;
  logic        valid_q, valid_d;

  logic        redirect;
  logic [31:0] pc_plus4;
  logic        load;        // a fetched word is delivered to IF/ID this cycle
  logic [31:0] load_instr;  // the word being delivered
  logic        drop;        // a response is being discarded this cycle

  assign redirect = (pcSrc != 2'b00);
  assign pc_plus4 = pc_q + 32'd4;

  assign imemReq  = rst_n && (state_q == S_REQ);
  assign imemAddr = pc_q;
  assign pcF      = pc_q;
  assign pcPlus4F = pc_plus4;
  assign instrD   = instr_q;
  assign pcD      = pcD_q;
  assign pcPlus4D = pcp4D_q;
  assign validD   = valid_q;

  // Fetch FSM next-state, PC update and hold-register capture.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    hold_d     = hold_q;
    load       = 1'b0;
    load_instr = hold_q;
    drop       = 1'b0;
    case (state_q)
      S_REQ: begin
        if (redirect) begin
          pc_d = pcNext;
          // An accepted request for the old PC must have its response dropped.
          if (imemReady) state_d = S_DROP;
        end else if (imemReady) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect) begin
          pc_d = pcNext;
          if (imemRvalid) begin
            drop    = 1'b1;
            state_d = S_REQ;
          end else begin
            state_d = S_DROP;
          end
        end else if (imemRvalid) begin
          if (!stallD) begin
            load       = 1'b1;
            load_instr = imemRdata;
            pc_d       = pc_plus4;
            state_d    = S_REQ;
          end else begin
            hold_d  = imemRdata;
            state_d = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (redirect) begin
          pc_d    = pcNext;
          hold_d  = 32'd0;
          drop    = 1'b1;
          state_d = S_REQ;
        end else if (!stallD) begin
          load       = 1'b1;
          load_instr = hold_q;
          pc_d       = pc_plus4;
          state_d    = S_REQ;
        end
      end
      S_DROP: begin
        // A redirect only moves the PC; the stale response must still drain.
        if (redirect) pc_d = pcNext;
        if (imemRvalid) begin
          drop    = 1'b1;
          state_d = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase
  end

  // IF/ID next value: redirect/flush > stall > load > bubble.
  always_comb begin
    instr_d = instr_q;
    pcD_d   = pcD_q;
    pcp4D_d = pcp4D_q;
    valid_d = valid_q;
    if (redirect || flushD) begin
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end else if (stallD) begin
      instr_d = instr_q;
    end else if (load) begin
      instr_d = load_instr;
      pcD_d   = pc_q;
      pcp4D_d = pc_plus4;
      valid_d = 1'b1;
    end else begin
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end
  end

  // FSM state, PC and hold register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      hold_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      hold_q  <= hold_d;
    end
  end

  // IF/ID pipeline register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      instr_q <= NOP_INSTR;
      pcD_q   <= 32'd0;
      pcp4D_q <= 32'd0;
      valid_q <= 1'b0;
    end else begin
      instr_q <= instr_d;
      pcD_q   <= pcD_d;
      pcp4D_q <= pcp4D_d;
      valid_q <= valid_d;
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] fetchCnt_q, fetchCnt_d;
  logic [31:0] dropCnt_q, dropCnt_d;

  // Saturating event counters: real IF/ID loads and discarded responses.
  always_comb begin
    fetchCnt_d = fetchCnt_q;
    dropCnt_d  = dropCnt_q;
    if (load && !flushD && (fetchCnt_q != 32'hFFFF_FFFF)) fetchCnt_d = fetchCnt_q + 32'd1;
    if (drop && (dropCnt_q != 32'hFFFF_FFFF))             dropCnt_d  = dropCnt_q + 32'd1;
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetchCnt_q <= 32'd0;
      dropCnt_q  <= 32'd0;
    end else begin
      fetchCnt_q <= fetchCnt_d;
      dropCnt_q  <= dropCnt_d;
    end
  end

  assign fetchCount = fetchCnt_q;
  assign dropCount  = dropCnt_q;
`endif

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage of the pipelined RV32I core.
- Owns the PC register and issues requests to instruction memory over a ready/valid handshake.
- Loads fetched words into the IF/ID pipeline register.
- Produces pcF/pcPlus4F for the next-PC selector and consumes its selected next PC and pcSrc redirect code. Handles stall, flush and in-flight discard on redirect.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, instruction word driven into IF/ID on bubble/flush (addi x0,x0,0).

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- pcNext  input  32  next PC from the PC selector; used only on redirect.
- pcSrc  input  2  PC selector code from EX; redirect = (pcSrc != 2'b00).
- stallD  input  1  hazard unit: hold IF/ID contents.
- flushD  input  1  hazard unit: replace IF/ID with bubble.
- imemReq  output  1  fetch request valid.
- imemAddr  output  32  fetch address (= pcF).
- imemReady  input  1  memory accepts request this cycle when imemReq=1.
- imemRvalid  input  1  read data valid.
- imemRdata  input  32  fetched instruction word.
- pcF  output  32  current fetch PC.
- pcPlus4F  output  32  pcF + 4, modulo 2^32; to PC selector.
- instrD  output  32  IF/ID instruction.
- pcD  output  32  IF/ID PC.
- pcPlus4D  output  32  IF/ID PC+4.
- validD  output  1  IF/ID holds a real instruction.

Behaviour:
- Clock/reset: clock is clk; reset is rst_n, synchronous, active-low.
- Reset values: pcF=RESET_PC, instrD=NOP_INSTR, pcD=0, pcPlus4D=0, validD=0, state=S_REQ, hold register cleared. imemReq=0 while rst_n=0. Reset mid-transaction abandons any outstanding request; a response arriving after reset is ignored unless in S_WAIT (memory must be reset together with the core).
- At most one outstanding request. imemReq = (state==S_REQ). imemAddr = pcF.
- States and transitions:
  - S_REQ:
    - redirect: pcF<=pcNext; if imemReady this cycle go S_DROP, else stay S_REQ.
    - else imemReady: go S_WAIT.
  - S_WAIT:
    - redirect: pcF<=pcNext; if imemRvalid this cycle go S_REQ (response discarded), else go S_DROP.
    - else imemRvalid and stallD=0: IF/ID <= {imemRdata, pcF, pcF+4}, validD<=1, pcF<=pcF+4, go S_REQ.
    - else imemRvalid and stallD=1: capture imemRdata into hold register, go S_HOLD.
  - S_HOLD:
    - redirect: drop held word, pcF<=pcNext, go S_REQ.
    - else stallD=0: IF/ID <= {held, pcF, pcF+4}, validD<=1, pcF<=pcF+4, go S_REQ.
  - S_DROP: on imemRvalid discard data, go S_REQ. A redirect here updates pcF and stays S_DROP.
- IF/ID update priority: rst_n > (redirect or flushD) > stallD > load > bubble.
  - Redirect or flushD: instrD=NOP_INSTR, validD=0, pcD/pcPlus4D hold.
  - stallD: all IF/ID fields hold.
  - Bubble: no load and not stalled gives instrD=NOP_INSTR, validD=0.
- Latency: request accepted cycle N → earliest imemRvalid N+1 → IF/ID valid after edge N+1. Peak throughput is one instruction per 2 cycles.
- pcF/pcNext alignment is not checked. The PC wraps 32'hFFFF_FFFC → 0.

Optional Feature:
- FETCH_PERF_EN defined: adds output ports fetchCount[31:0] and dropCount[31:0], both reset to 0 and saturating at 32'hFFFF_FFFF.
  - fetchCount increments on each IF/ID load with validD<=1.
  - dropCount increments on each discarded response (S_DROP response, S_WAIT redirect+rvalid, S_HOLD redirect).
- Not defined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Reset with RESET_PC=0x100, release, memory ready/rvalid next cycle with 0x00500093 → imemAddr=0x100; instrD=0x00500093, pcD=0x100, pcPlus4D=0x104, validD=1; pcF=0x104.
- Straight-line fetch of 4 words, always-ready memory → pcD sequence 0x0,0x4,0x8,0xC, one valid instr every 2 cycles, bubbles (NOP, validD=0) in between.
- Response arrives with stallD=1 for 3 cycles → IF/ID unchanged, state S_HOLD, no imemReq. Stall release → held word loaded, then next request at pcF+4.
- Request accepted at PC 0x20, pcSrc=2'b01 and pcNext=0x80 the next cycle before rvalid → response for 0x20 discarded (validD stays 0), next imemAddr=0x80; dropCount=1 when FETCH_PERF_EN.
- flushD and stallD asserted together with valid IF/ID → instrD=0x00000013, validD=0.
- Assert rst_n=0 while in S_WAIT → next cycle pcF=RESET_PC, validD=0, imemReq=0; after release a fresh request at RESET_PC.
